fpu_req_arbiter: RTL and testbench
==================================

Name: fpu_req_arbiter

Overview:
- Shares one fixed-latency single-precision FPU datapath (operand check + exception flag stage plus arithmetic) between two requesters.
- Arbitrates round-robin and launches at most one operation per cycle.
- Tags each in-flight operation with its requester ID and routes result plus exception flags back to that requester.
- Provides a flush/drain handshake so software-visible state can be quiesced; sits between the issue logic and the shared FPU core.

Parameters:
LAT, 2, cycles from fpu_start asserted to fpu_result/fpu_flags valid at datapath output (legal 1..8)
OPW, 3, width of operation code forwarded to FPU

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_opa  in  32  requester 0 operand A (IEEE-754 single)
req0_opb  in  32  requester 0 operand B
req0_op  in  OPW  requester 0 opcode
req1_valid / req1_ready / req1_opa / req1_opb / req1_op  same as requester 0, for requester 1
fpu_start  out  1  launch strobe to FPU, registered
fpu_opa  out  32  registered operand A to FPU
fpu_opb  out  32  registered operand B to FPU
fpu_op  out  OPW  registered opcode to FPU
fpu_result  in  32  FPU result, valid LAT cycles after fpu_start
fpu_flags  in  5  FPU flags {snan,qnan,inf,ind,dn}, aligned with fpu_result
rsp_valid  out  1  one-cycle response strobe, registered
rsp_id  out  1  requester owning the response
rsp_result  out  32  registered result
rsp_flags  out  5  registered flags
flush  in  1  level request: stop accepting, drain pipeline
flush_done  out  1  one-cycle pulse when pipeline is empty after flush
sticky0  out  5  requester 0 accumulated flags (optional feature)
sticky1  out  5  requester 1 accumulated flags (optional feature)
sticky_clr  in  2  per-requester sticky clear (optional feature)

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs 0; state=IDLE; rr pointer=0 (requester 0 favoured); in-flight tag pipe cleared. Reset mid-operation discards in-flight ops; no rsp_valid is produced for them, and FPU outputs are ignored until new launches retire.
- FSM:
  - IDLE: no ops in flight. Any valid with flush=0 -> RUN. flush=1 -> DRAIN.
  - RUN: ops in flight or accepting. flush=1 -> DRAIN. Pipe empty with no acceptance -> IDLE.
  - DRAIN: no acceptance. When tag pipe and the response stage are empty, pulse flush_done for one cycle, then go to IDLE if flush=0, or stay in DRAIN with no further pulse while flush=1.
- Acceptance:
  - reqX_ready is combinational and asserted only when state is not DRAIN, flush=0, reqX_valid=1 and X wins arbitration. At most one ready per cycle.
  - Round-robin: if only one requester is valid, it wins. If both are valid, the requester not granted last wins. The pointer updates only on acceptance.
- Launch: operation accepted at cycle t gives fpu_start=1 with fpu_opa/opb/op at t+1. fpu_start=0 in cycles with no acceptance, and fpu_opa/opb/op hold their last values.
- Tagging: a LAT-deep shift register of {valid,id} advances every cycle, entered at fpu_start.
- Response: when the tag emerges at t+1+LAT, capture fpu_result/fpu_flags. rsp_valid=1 at t+2+LAT with the captured rsp_id, rsp_result and rsp_flags.
  - Total latency from accept to rsp_valid is LAT+2. Throughput is 1 op/cycle. No response backpressure.
  - Responses are returned in launch order.
  - rsp_result/rsp_flags hold their values when rsp_valid=0.
- Simultaneous flush and valid in the same cycle: flush wins, no acceptance.

Optional Feature:
FPU_ARB_STICKY_EN
- Defined:
  - Each response ORs rsp_flags into sticky[rsp_id] in the cycle rsp_valid=1, so the update is visible the following cycle.
  - sticky_clr[i]=1 clears sticky i. If a clear and a set for the same requester occur in the same cycle, the set wins: the register takes the new flags only.
  - Reset value is 0.
- Undefined: sticky0/sticky1 are tied to 0, sticky_clr is ignored, and no sticky registers are built.

Test Plan:
- Solo issue, LAT=2: req0 opa=0x7F800000 opb=0x3F800000 accepted at cycle 10 -> fpu_start at 11; bench FPU returns flags 5'b00100 at 13; rsp_valid=1, rsp_id=0, rsp_flags=5'b00100 at 14.
- Contention: req0 and req1 both held valid for 4 cycles after reset -> grant order 0,1,0,1; responses return with rsp_id sequence 0,1,0,1, back-to-back.
- Flush while busy: 3 ops in flight, flush=1 -> req ready stays 0; flush_done pulses exactly once, one cycle after the third rsp_valid; flush held high -> no second pulse.
- Reset mid-stream: rst_n=0 for 1 cycle with 2 ops in flight -> no rsp_valid afterwards for those ops; all outputs 0; first post-reset contention grants req0.
- FPU_ARB_STICKY_EN: req1 gets flags 5'b10000 then 5'b00001 -> sticky1=5'b10001, sticky0=0; sticky_clr=2'b10 coinciding with a new req1 response of 5'b01000 -> sticky1=5'b01000.

Source files
------------

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: two-requester round-robin front end for a shared
// fixed-latency FPU datapath. Launches at most one op per cycle, tags each
// launch with its requester, returns result/flags in launch order, and
// supports a flush/drain handshake.
// Optional build macro FPU_ARB_STICKY_EN adds per-requester sticky flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | nothing in flight, accepting
// S_RUN     | ops in flight and/or accepting
// S_DRAIN   | flush seen, not accepting, waiting for pipeline to empty
// S_DRAINED | flush_done already pulsed, waiting for flush to drop
module fpu_req_arbiter #(
    parameter int LAT = 2,
    parameter int OPW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_opa,
    input  logic [31:0]     req0_opb,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_opa,
    input  logic [31:0]     req1_opb,
    input  logic [OPW-1:0]  req1_op,
    output logic            fpu_start,
    output logic [31:0]     fpu_opa,
    output logic [31:0]     fpu_opb,
    output logic [OPW-1:0]  fpu_op,
    input  logic [31:0]     fpu_result,
    input  logic [4:0]      fpu_flags,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [31:0]     rsp_result,
    output logic [4:0]      rsp_flags,
    input  logic            flush,
    output logic            flush_done,
    output logic [4:0]      sticky0,
    output logic [4:0]      sticky1,
    input  logic [1:0]      sticky_clr
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DRAINED} state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;       // requester favoured on contention
    logic            fpu_start_q;
    logic            start_id_q;
    logic [31:0]     fpu_opa_q, fpu_opb_q;
    logic [OPW-1:0]  fpu_op_q;
    logic [LAT-1:0]  tag_vld_q, tag_id_q;
    logic [LAT:0]    tag_vld_ext, tag_id_ext;
    logic            rsp_valid_q, rsp_id_q;
    logic [31:0]     rsp_result_q;
    logic [4:0]      rsp_flags_q;

    logic            accept_en, gnt0, gnt1, accept, acc_id, busy;

    // Arbitration: the favoured requester wins only when both are valid.
    always_comb begin
        accept_en  = rst_n && !flush && (state_q == S_IDLE || state_q == S_RUN);
        gnt1       = req1_valid && (!req0_valid || prio_q);
        gnt0       = req0_valid && !gnt1;
        req0_ready = accept_en && gnt0;
        req1_ready = accept_en && gnt1;
        accept     = req0_ready || req1_ready;
        acc_id     = req1_ready;
        prio_d     = accept ? ~acc_id : prio_q;
    end

    // Anything launched, tagged or waiting in the response stage counts as busy.
    assign busy        = fpu_start_q || (|tag_vld_q) || rsp_valid_q;
    assign tag_vld_ext = {tag_vld_q, fpu_start_q};
    assign tag_id_ext  = {tag_id_q, start_id_q};

    // Next-state logic and the flush_done pulse.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush)       state_d = S_DRAIN;
                else if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                if (flush)                 state_d = S_DRAIN;
                else if (!busy && !accept) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (!busy) begin
                    flush_done = rst_n;
                    state_d    = flush ? S_DRAINED : S_IDLE;
                end
            end
            S_DRAINED: begin
                if (!flush) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, arbitration pointer, launch register, tag pipe and response stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            fpu_start_q  <= 1'b0;
            start_id_q   <= 1'b0;
            fpu_opa_q    <= '0;
            fpu_opb_q    <= '0;
            fpu_op_q     <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            fpu_start_q <= accept;
            start_id_q  <= acc_id;
            if (accept) begin
                fpu_opa_q <= acc_id ? req1_opa : req0_opa;
                fpu_opb_q <= acc_id ? req1_opb : req0_opb;
                fpu_op_q  <= acc_id ? req1_op  : req0_op;
            end
            tag_vld_q   <= tag_vld_ext[LAT-1:0];
            tag_id_q    <= tag_id_ext[LAT-1:0];
            rsp_valid_q <= tag_vld_q[LAT-1];
            if (tag_vld_q[LAT-1]) begin
                rsp_id_q     <= tag_id_q[LAT-1];
                rsp_result_q <= fpu_result;
                rsp_flags_q  <= fpu_flags;
            end
        end
    end

    assign fpu_start  = fpu_start_q;
    assign fpu_opa    = fpu_opa_q;
    assign fpu_opb    = fpu_opb_q;
    assign fpu_op     = fpu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

`ifdef FPU_ARB_STICKY_EN
    logic [4:0] sticky0_q, sticky0_d, sticky1_q, sticky1_d;

    // Clear first, then OR in the response: a same-cycle set keeps only new flags.
    always_comb begin
        sticky0_d = sticky_clr[0] ? 5'b0 : sticky0_q;
        sticky1_d = sticky_clr[1] ? 5'b0 : sticky1_q;
        if (rsp_valid_q && !rsp_id_q) sticky0_d = sticky0_d | rsp_flags_q;
        if (rsp_valid_q &&  rsp_id_q) sticky1_d = sticky1_d | rsp_flags_q;
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky0_q <= '0;
            sticky1_q <= '0;
        end else begin
            sticky0_q <= sticky0_d;
            sticky1_q <= sticky1_d;
        end
    end

    assign sticky0 = sticky0_q;
    assign sticky1 = sticky1_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = |sticky_clr;
    assign sticky0 = 5'b0;
    assign sticky1 = 5'b0;
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Testbench for fpu_req_arbiter (LAT=2): cycle table plus directed sequences.
module tb_fpu_req_arbiter;

    localparam int LAT = 2;
    localparam int OPW = 3;
`ifdef FPU_ARB_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h4000_0000, B0 = 32'h0000_0002;
    localparam logic [31:0] A1 = 32'h4100_0000, B1 = 32'h0000_0008;
    localparam logic [4:0]  F0 = 5'b00010, F1 = 5'b01000;
    localparam logic [31:0] R0 = 32'h4000_0002, R1 = 32'h4100_0008;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
    logic [OPW-1:0] req0_op, req1_op;
    logic fpu_start;
    logic [31:0] fpu_opa, fpu_opb, fpu_result;
    logic [OPW-1:0] fpu_op;
    logic [4:0] fpu_flags;
    logic rsp_valid, rsp_id;
    logic [31:0] rsp_result;
    logic [4:0] rsp_flags;
    logic flush, flush_done;
    logic [4:0] sticky0, sticky1;
    logic [1:0] sticky_clr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_req_arbiter #(.LAT(LAT), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
        .req0_opb(req0_opb), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
        .req1_opb(req1_opb), .req1_op(req1_op),
        .fpu_start(fpu_start), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .flush(flush), .flush_done(flush_done),
        .sticky0(sticky0), .sticky1(sticky1), .sticky_clr(sticky_clr)
    );

    // Stand-in FPU: result = opa+opb; flags = inf-operand marker or opb[4:0].
    logic m_v0 = 1'b0, m_v1 = 1'b0;
    logic [31:0] m_r0, m_r1;
    logic [4:0] m_f0, m_f1;
    always @(posedge clk) begin
        m_v0 <= fpu_start;
        m_r0 <= fpu_opa + fpu_opb;
        m_f0 <= (fpu_opa == 32'h7F80_0000) ? 5'b00100 : fpu_opb[4:0];
        m_v1 <= m_v0;
        m_r1 <= m_r0;
        m_f1 <= m_f0;
    end
    assign fpu_result = m_v1 ? m_r1 : 32'hDEAD_BEEF;
    assign fpu_flags  = m_v1 ? m_f1 : 5'b11111;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic r0v, r1v, fl;
        logic rdy0, rdy1, st;
        logic [31:0] opa;
        logic rv, rid;
        logic [4:0] rfl;
        logic [31:0] res;
        logic done;
    } vec_t;

    // osel: 0 none launched yet, 1 A0, 2 A1; rsel: 0 none yet, 1 req0 rsp, 2 req1 rsp
    function automatic vec_t mk(input logic r0v, r1v, fl, rdy0, rdy1, st,
                                input int osel, input logic rv, input int rsel,
                                input logic done);
        vec_t v;
        v.r0v = r0v; v.r1v = r1v; v.fl = fl;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.st = st;
        v.opa = (osel == 1) ? A0 : (osel == 2) ? A1 : 32'h0;
        v.rv = rv;
        v.rid = (rsel == 2);
        v.rfl = (rsel == 1) ? F0 : (rsel == 2) ? F1 : 5'b0;
        v.res = (rsel == 1) ? R0 : (rsel == 2) ? R1 : 32'h0;
        v.done = done;
        return v;
    endfunction

    // One op from requester id (optionally contended); checks launch, latency, response.
    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ef, input bit both, input logic [1:0] clr);
        int lat;
        bit found;
        if (id) begin req1_opa = a; req1_opb = b; end
        else    begin req0_opa = a; req0_opb = b; end
        req0_valid = !id || both;
        req1_valid = id || both;
        @(negedge clk);
        chk("issue_ready", id ? req1_ready : req0_ready, 1);
        chk("issue_other_ready", id ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("issue_start", fpu_start, 1);
        chk("issue_opa", fpu_opa, a);
        chk("issue_op", fpu_op, id ? 3'd2 : 3'd5);
        found = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
                sticky_clr = (k == 4) ? clr : 2'b00;
                @(negedge clk);
            end
            if (rsp_valid) begin
                found = 1;
                lat = k;
                break;
            end
        end
        chk("issue_rsp_seen", found, 1);
        chk("issue_latency", lat, 4);
        chk("issue_rsp_id", rsp_id, id);
        chk("issue_rsp_flags", rsp_flags, ef);
        chk("issue_rsp_result", rsp_result, a + b);
        @(posedge clk); #1;
        sticky_clr = 2'b00;
    endtask

    vec_t tv[26];

    initial begin
        tv[0]  = mk(1,1,0, 1,0,0, 0, 0,0, 0);
        tv[1]  = mk(1,1,0, 0,1,1, 1, 0,0, 0);
        tv[2]  = mk(1,1,0, 1,0,1, 2, 0,0, 0);
        tv[3]  = mk(1,1,0, 0,1,1, 1, 0,0, 0);
        tv[4]  = mk(0,0,0, 0,0,1, 2, 1,1, 0);
        tv[5]  = mk(0,0,0, 0,0,0, 2, 1,2, 0);
        tv[6]  = mk(0,0,0, 0,0,0, 2, 1,1, 0);
        tv[7]  = mk(0,0,0, 0,0,0, 2, 1,2, 0);
        tv[8]  = mk(0,0,0, 0,0,0, 2, 0,2, 0);
        tv[9]  = mk(0,1,0, 0,1,0, 2, 0,2, 0);
        tv[10] = mk(1,1,0, 1,0,1, 2, 0,2, 0);
        tv[11] = mk(0,1,0, 0,1,1, 1, 0,2, 0);
        tv[12] = mk(1,1,1, 0,0,1, 2, 0,2, 0);
        tv[13] = mk(1,1,1, 0,0,0, 2, 1,2, 0);
        tv[14] = mk(1,1,1, 0,0,0, 2, 1,1, 0);
        tv[15] = mk(1,1,1, 0,0,0, 2, 1,2, 0);
        tv[16] = mk(0,0,1, 0,0,0, 2, 0,2, 1);
        tv[17] = mk(0,0,1, 0,0,0, 2, 0,2, 0);
        tv[18] = mk(1,0,1, 0,0,0, 2, 0,2, 0);
        tv[19] = mk(0,0,0, 0,0,0, 2, 0,2, 0);
        tv[20] = mk(1,1,0, 1,0,0, 2, 0,2, 0);
        tv[21] = mk(0,0,0, 0,0,1, 1, 0,2, 0);
        tv[22] = mk(0,0,0, 0,0,0, 1, 0,2, 0);
        tv[23] = mk(0,0,0, 0,0,0, 1, 0,2, 0);
        tv[24] = mk(0,0,0, 0,0,0, 1, 1,1, 0);
        tv[25] = mk(0,0,0, 0,0,0, 1, 0,1, 0);

        rst_n = 0; flush = 0; sticky_clr = 2'b00;
        req0_valid = 0; req1_valid = 0;
        req0_opa = A0; req0_opb = B0; req0_op = 3'd5;
        req1_opa = A1; req1_opb = B1; req1_op = 3'd2;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_fpu_opa", fpu_opa, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_sticky", {sticky1, sticky0}, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // cycle table: contention, idle return, solo req1, flush drain, restart
        for (int i = 0; i < 26; i++) begin
            req0_valid = tv[i].r0v;
            req1_valid = tv[i].r1v;
            flush      = tv[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d_ready0", i), req0_ready, tv[i].rdy0);
            chk($sformatf("v%0d_ready1", i), req1_ready, tv[i].rdy1);
            chk($sformatf("v%0d_fpu_start", i), fpu_start, tv[i].st);
            chk($sformatf("v%0d_fpu_opa", i), fpu_opa, tv[i].opa);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, tv[i].rv);
            chk($sformatf("v%0d_rsp_id", i), rsp_id, tv[i].rid);
            chk($sformatf("v%0d_rsp_flags", i), rsp_flags, tv[i].rfl);
            chk($sformatf("v%0d_rsp_result", i), rsp_result, tv[i].res);
            chk($sformatf("v%0d_flush_done", i), flush_done, tv[i].done);
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0; flush = 0;

        // solo issue of an infinity operand
        issue(0, 32'h7F80_0000, 32'h3F80_0000, 5'b00100, 0, 2'b00);

        // reset with two ops in flight (pointer favours req1 now)
        req0_opa = A0; req0_opb = B0; req1_opa = A1; req1_opb = B1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("mid_grant1", {req0_ready, req1_ready}, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_grant2", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_outputs", {fpu_start, rsp_valid, flush_done, rsp_id}, 0);
        chk("mid_rst_opa", fpu_opa, 0);
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_flags", rsp_flags, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("mid_no_rsp%0d", k), rsp_valid, 0);
        end
        @(posedge clk); #1;
        // first post-reset contention must go to req0
        issue(0, 32'h3F80_0000, 32'h0, 5'b00000, 1, 2'b00);

        // sticky flag accumulation and clear-vs-set
        issue(1, 32'h0, 32'h10, 5'b10000, 0, 2'b00);
        issue(1, 32'h0, 32'h01, 5'b00001, 0, 2'b00);
        @(negedge clk);
        chk("sticky1_acc", sticky1, STK ? 5'b10001 : 5'b0);
        chk("sticky0_acc", sticky0, 0);
        @(posedge clk); #1;
        issue(1, 32'h0, 32'h08, 5'b01000, 0, 2'b10);
        @(negedge clk);
        chk("sticky1_clr_set", sticky1, STK ? 5'b01000 : 5'b0);
        chk("sticky0_clr_set", sticky0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
